// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_bank
// Purpose  : Bank of N_CNT hardware performance counters for the CSR unit.
//            Each channel counts qualifying events (evt_i & ~inhibit_i) in
//            steps of INC, modulo 2^CNT_W. Counters are read and written
//            in XLEN-wide halves. Reads have 1-cycle latency; writes take
//            effect at the edge where wr_en_i is high.
// Macro    : PERF_CNT_SNAPSHOT_EN - when defined, a low-half read latches
//            the high half into a shadow register. A following high-half
//            read of the same channel returns that shadow value, so the
//            two halves are coherent.
// Ports    : clk, rst_n            - clock, async active-low reset
//            evt_i, inhibit_i      - per-channel event strobe / inhibit
//            rd_req_i, rd_idx_i,
//            rd_hi_i               - read request, channel, half select
//            rd_data_o, rd_valid_o - read data (held when not valid), valid
//            wr_en_i, wr_idx_i,
//            wr_hi_i, wr_data_i    - write strobe, channel, half, data
//            ovf_o                 - registered per-channel overflow pulse
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter_bank #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64,
    parameter int N_CNT = 5,
    parameter int INC   = 1,
    parameter int IDX_W = (N_CNT > 1) ? $clog2(N_CNT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CNT-1:0] evt_i,
    input  logic [N_CNT-1:0] inhibit_i,
    input  logic             rd_req_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic             rd_hi_i,
    output logic [XLEN-1:0]  rd_data_o,
    output logic             rd_valid_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_hi_i,
    input  logic [XLEN-1:0]  wr_data_i,
    output logic [N_CNT-1:0] ovf_o
);

    // A high half only exists when the counter is twice the CSR width.
    localparam bit c_has_hi = (CNT_W > XLEN);
    // The read mux covers every encodable index. Slots at or above N_CNT
    // are tied to zero, so out-of-range reads return 0 with no extra compare.
    localparam int c_slots  = 2 ** IDX_W;

    logic [CNT_W-1:0] w_cnt [c_slots];
    logic [CNT_W-1:0] w_rd_cnt;
    logic [XLEN-1:0]  w_rd_lo;
    logic [XLEN-1:0]  w_live_hi;
    logic [XLEN-1:0]  w_hi_val;
    logic [XLEN-1:0]  r_rd_data;
    logic             r_rd_valid;

    // ------------------------------------------------------------------
    // Counter channels
    // ------------------------------------------------------------------
    generate
        for (genvar c = 0; c < c_slots; c++) begin : g_slot
            if (c < N_CNT) begin : g_live
                logic [CNT_W-1:0] r_cnt;
                logic             r_ovf;
                logic [CNT_W-1:0] w_wr_val;
                logic [CNT_W:0]   w_sum;
                logic             w_wr_hit;
                logic             w_inc;

                // A high-half write to a single-width counter is dropped. It
                // does not count as a write, so an increment still applies.
                assign w_wr_hit = wr_en_i && (wr_idx_i == IDX_W'(c))
                                  && (!wr_hi_i || c_has_hi);
                assign w_inc    = evt_i[c] && !inhibit_i[c];
                // One extra bit captures the carry out of the MSB.
                assign w_sum    = {1'b0, r_cnt} + (CNT_W + 1)'(INC);

                if (c_has_hi) begin : g_split
                    assign w_wr_val = wr_hi_i ? {wr_data_i, r_cnt[XLEN-1:0]}
                                              : {r_cnt[CNT_W-1:XLEN], wr_data_i};
                end else begin : g_flat
                    assign w_wr_val = wr_data_i;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end else if (w_wr_hit) begin
                        r_cnt <= w_wr_val;
                        r_ovf <= 1'b0;
                    end else if (w_inc) begin
                        r_cnt <= w_sum[CNT_W-1:0];
                        r_ovf <= w_sum[CNT_W];
                    end else begin
                        r_ovf <= 1'b0;
                    end
                end

                assign w_cnt[c]  = r_cnt;
                assign ovf_o[c]  = r_ovf;
            end else begin : g_pad
                assign w_cnt[c] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read path. The value is taken from the counters before this edge's
    // update, so same-cycle writes and increments are not visible here.
    // ------------------------------------------------------------------
    assign w_rd_cnt = w_cnt[rd_idx_i];
    assign w_rd_lo  = w_rd_cnt[XLEN-1:0];

    generate
        if (c_has_hi) begin : g_hi_rd
            assign w_live_hi = w_rd_cnt[CNT_W-1:XLEN];
        end else begin : g_no_hi_rd
            assign w_live_hi = '0;
        end
    endgenerate

`ifdef PERF_CNT_SNAPSHOT_EN
    logic [XLEN-1:0]  r_snap_hi;
    logic             r_snap_valid;
    logic [IDX_W-1:0] r_snap_idx;
    logic             w_snap_hit;
    logic             w_snap_set;
    logic [IDX_W-1:0] w_snap_idx_nxt;

    assign w_snap_hit     = r_snap_valid && (r_snap_idx == rd_idx_i);
    assign w_snap_set     = rd_req_i && !rd_hi_i && c_has_hi
                            && (32'(rd_idx_i) < N_CNT);
    // A write is checked against the channel the shadow will hold after
    // this edge. A low read and a write to the same channel in one cycle
    // therefore leave no stale shadow behind.
    assign w_snap_idx_nxt = w_snap_set ? rd_idx_i : r_snap_idx;
    assign w_hi_val       = w_snap_hit ? r_snap_hi : w_live_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_hi    <= '0;
            r_snap_valid <= 1'b0;
            r_snap_idx   <= '0;
        end else begin
            if (w_snap_set) begin
                r_snap_hi    <= w_live_hi;
                r_snap_valid <= 1'b1;
                r_snap_idx   <= rd_idx_i;
            end else if (rd_req_i && rd_hi_i && w_snap_hit) begin
                r_snap_valid <= 1'b0;
            end
            if (wr_en_i && (wr_idx_i == w_snap_idx_nxt)) begin
                r_snap_valid <= 1'b0;
            end
        end
    end
`else
    assign w_hi_val = w_live_hi;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_req_i;
            if (rd_req_i) begin
                r_rd_data <= rd_hi_i ? w_hi_val : w_rd_lo;
            end
        end
    end

    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;

endmodule
`default_nettype wire

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised bank of hardware performance counters feeding the CSR unit. It generalises the fixed CYCLE/INSTR/FLUSH/WAIT/DECOD counter pairs to N channels of configurable width and increment. Reads are split into XLEN-wide halves, with an optional coherent high-half snapshot. The block sits beside the CSR file and is accessed through a 1-cycle-latency read port and a same-cycle write port.

## Interface
- XLEN, 32, CSR data width; legal values 32 or 64.
- CNT_W, 64, counter width; must equal XLEN or 2*XLEN.
- N_CNT, 5, number of counter channels; 1..16.
- INC, 1, increment added per qualifying event; 1..255.
- IDX_W, $clog2(N_CNT) (min 1), channel index width; derived.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- evt_i  in  N_CNT  per-channel event strobe, sampled every cycle.
- inhibit_i  in  N_CNT  per-channel count inhibit (mcountinhibit style).
- rd_req_i  in  1  read request.
- rd_idx_i  in  IDX_W  read channel.
- rd_hi_i  in  1  1 selects bits [CNT_W-1:XLEN].
- rd_data_o  out  XLEN  read data.
- rd_valid_o  out  1  read data valid.
- wr_en_i  in  1  write strobe.
- wr_idx_i  in  IDX_W  write channel.
- wr_hi_i  in  1  write high half.
- wr_data_i  in  XLEN  write data.
- ovf_o  out  N_CNT  1-cycle overflow pulse per channel.

## Operation
- Each cycle, for each channel c: if the channel is being written this cycle, the write applies and no increment occurs. Otherwise cnt[c] <= cnt[c] + INC when evt_i[c] & ~inhibit_i[c].
- Arithmetic is modulo 2^CNT_W. If an increment carries out of the MSB, ovf_o[c] pulses on the following cycle while the counter wraps.
- A write replaces only the addressed half; the other half is unchanged.
- When CNT_W == XLEN, wr_hi_i=1 writes are ignored and high reads return 0.
- Read: rd_data_o shows the low or high half of cnt[rd_idx_i], sampled at the clock edge where rd_req_i is high.
- A read and a write to the same channel in the same cycle return the pre-write value.
- A read and an increment in the same cycle return the pre-increment value.
- An out-of-range index (>= N_CNT) reads 0 and ignores writes, with no error signalled.
- The high half (CNT_W == 2*XLEN) follows the snapshot rules in Configuration.

## Timing
- Reset: all counters 0, rd_data_o 0, rd_valid_o 0, ovf_o 0, snapshot valid flag 0.
- Reset mid-operation clears everything immediately (asynchronous); no pending read completes.
- Read latency is 1 cycle: rd_valid_o is high the cycle after rd_req_i, for exactly one cycle per request. Back-to-back requests give back-to-back valid cycles.
- rd_data_o holds its last value when rd_valid_o is 0.
- A write takes effect at the edge where wr_en_i is high and is visible to a read issued on the next cycle.
- ovf_o is registered, so each pulse appears 1 cycle after the wrapping edge.

## Configuration
- Macro: PERF_CNT_SNAPSHOT_EN.
- Defined:
  - A low-half read of channel c latches cnt[c][CNT_W-1:XLEN] into a shadow register and sets snap_valid with snap_idx=c.
  - A subsequent high read of the same channel returns the shadow value and clears snap_valid.
  - A high read of a different channel, or with snap_valid=0, returns the live high half.
  - Any write to channel snap_idx clears snap_valid.
- Undefined: the shadow logic is absent and high reads always return the live high half.

## Test plan
- Reset with evt_i=all 1s held for 10 cycles, INC=1, no inhibit -> every counter reads 10 (low half), high half 0, rd_valid_o exactly 1 cycle after each rd_req_i.
- inhibit_i[2]=1 with evt_i=all 1s for 5 cycles -> channel 2 stays 0 and the other channels read 5.
- Write low half 0xFFFF_FFFE on channel 0, then 3 events -> low half 0x0000_0001, high half 1, no ovf_o pulse.
- Write high and low halves to all 1s, then 1 event -> counter reads 0 and ovf_o[0] pulses for exactly 1 cycle, 1 cycle after the wrap.
- With PERF_CNT_SNAPSHOT_EN: set channel 1 to 0x0_FFFF_FFFF and read low while an event occurs, then read high -> low 0xFFFF_FFFF, high 0 (shadow), and a repeated high read returns live 1. Without the macro, the same sequence returns high 1.
- Write and event to the same channel in the same cycle -> written value with no increment. Read and write of index N_CNT -> 0 returned, no counter changes.
